// File: rtl/mul_unfold_pkg.sv
// Shared types and helpers for the unfolded multiplier sequencer.
package mul_unfold_pkg;

    // Sequencer states: wait for operands, accumulate slices, hold the product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Integer ceiling division, used to size the number of RUN cycles.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/mul_unfold_seq_if.sv
// Operand and result handshakes of the multiplier sequencer.
// master = operand source / result consumer, slave = sequencer.
interface mul_unfold_seq_if #(
    parameter int WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mul_pp_slice.sv
// Combinational partial product: WIDTH-bit multiplicand times a J-bit slice
// of the multiplier. The result is WIDTH+J bits and cannot overflow.
module mul_pp_slice #(
    parameter int WIDTH = 5,
    parameter int J     = 3
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [J-1:0]       slice_i,
    output logic [WIDTH+J-1:0] pp_o
);

    assign pp_o = (WIDTH+J)'(a_i) * (WIDTH+J)'(slice_i);

endmodule

// File: rtl/mul_unfold_seq.sv
// Sequencer for the unfolded array multiplier. Accepts (a, b), consumes b
// J bits per RUN cycle, accumulates shifted partial products and returns
// the 2*WIDTH-bit product. All outputs come straight from registers.
module mul_unfold_seq
    import mul_unfold_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int J     = 3
) (
    input  logic            clk,
    input  logic            reset,
    mul_unfold_seq_if.slave bus
);

    localparam int ITER = ceil_div(WIDTH, J);
    localparam int CW   = $clog2(ITER) + 1;
    localparam int PADW = ITER * J;
    localparam int PW   = 2 * WIDTH;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    a_q;
    logic [PADW-1:0]     b_q;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       p_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [J-1:0]        slice;
    logic [WIDTH+J-1:0]  pp;
    logic [PW-1:0]       acc_d;

    mul_pp_slice #(
        .WIDTH (WIDTH),
        .J     (J)
    ) u_pp_slice (
        .a_i     (a_q),
        .slice_i (slice),
        .pp_o    (pp)
    );

    // Select the current multiplier slice and form the next accumulator value.
    // b_q is zero-padded to ITER*J bits, so the top slice reads 0 above WIDTH.
    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    always_comb begin
        slice = b_q[J*int'(cnt_q) +: J];
        acc_d = acc_q + (PW'(pp) << (J*int'(cnt_q)));
    end

    // Sequencer FSM with operand registers, accumulator and registered outputs.
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= PADW'(bus.b);
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(ITER - 1)) begin
                        // Last slice: publish the product without an extra cycle.
                        p_q         <= acc_d;
                        acc_q       <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mul_unfold_seq.sv
// Self-checking bench for mul_unfold_seq: directed cases on the default
// J=3 instance, random pairs with backpressure, and exhaustive 32x32 sweeps
// on J=1 and J=5 instances. Expected products come from plain a*b.
module tb_mul_unfold_seq;

    localparam int ITER3 = 2;   // ceil(5/3)

    logic clk;
    logic reset;

    mul_unfold_seq_if #(.WIDTH(5)) if3 ();
    mul_unfold_seq_if #(.WIDTH(5)) if1 ();
    mul_unfold_seq_if #(.WIDTH(5)) if5 ();

    mul_unfold_seq #(.WIDTH(5), .J(3)) u_j3 (.clk(clk), .reset(reset), .bus(if3.slave));
    mul_unfold_seq #(.WIDTH(5), .J(1)) u_j1 (.clk(clk), .reset(reset), .bus(if1.slave));
    mul_unfold_seq #(.WIDTH(5), .J(5)) u_j5 (.clk(clk), .reset(reset), .bus(if5.slave));

    int total = 0;
    int bad   = 0;
    int q3[$];
    int q1[$];
    int q5[$];

    logic rand_bp3;
    logic or3_dir;
    logic rnd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Random backpressure sources, refreshed just after each rising edge.
    always @(posedge clk) begin
        #1;
        rnd3          = 1'($urandom_range(0, 1));
        if1.out_ready = 1'($urandom_range(0, 1));
        if5.out_ready = 1'($urandom_range(0, 1));
    end

    // J=3 consumer: directed level or random level.
    always_comb if3.out_ready = rand_bp3 ? rnd3 : or3_dir;

    // Scoreboard monitors: compare on every output transfer.
    always @(negedge clk) begin
        if (reset && if3.out_valid && if3.out_ready) begin
            if (q3.size() == 0) check("j3_spurious_output", 32'd1, 32'd0);
            else                check("j3_p", 32'(if3.p), 32'(q3.pop_front()));
        end
        if (reset && if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) check("j1_spurious_output", 32'd1, 32'd0);
            else                check("j1_p", 32'(if1.p), 32'(q1.pop_front()));
        end
        if (reset && if5.out_valid && if5.out_ready) begin
            if (q5.size() == 0) check("j5_spurious_output", 32'd1, 32'd0);
            else                check("j5_p", 32'(if5.p), 32'(q5.pop_front()));
        end
    end

    // Present a pair to the J=3 instance and hold it until accepted.
    task automatic send3(input logic [4:0] av, input logic [4:0] bv);
        int g = 0;
        @(posedge clk); #1;
        if3.in_valid = 1'b1;
        if3.a        = av;
        if3.b        = bv;
        do begin
            @(negedge clk);
            g++;
        end while (!if3.in_ready && g < 200);
        if (!if3.in_ready) check("send3_accept_timeout", 32'd0, 32'd1);
        q3.push_back(int'(av) * int'(bv));
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
    endtask

    // Send a pair and measure cycles from the accept edge to out_valid.
    task automatic txn3(input logic [4:0] av, input logic [4:0] bv, input string nm);
        int k = 0;
        send3(av, bv);
        do begin
            @(negedge clk);
            k++;
        end while (!if3.out_valid && k < 50);
        check({nm, "_latency"}, 32'(k), 32'(ITER3 + 1));
    endtask

    // Wait until every expected product has been observed.
    task automatic drain(input string nm);
        int g = 0;
        while ((q3.size() + q1.size() + q5.size()) != 0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_drained"}, 32'(q3.size() + q1.size() + q5.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        rand_bp3 = 1'b0;
        or3_dir  = 1'b1;
        if3.in_valid = 1'b0; if3.a = '0; if3.b = '0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
        if5.in_valid = 1'b0; if5.a = '0; if5.b = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(if3.out_valid), 32'd0);
        check("rst_busy",      32'(if3.busy),      32'd0);
        check("rst_p",         32'(if3.p),         32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(if3.in_ready),  32'd1);

        // 1: single pair, exact latency and a one-cycle pulse.
        txn3(5'd5, 5'd3, "t1");
        check("t1_p", 32'(if3.p), 32'd15);
        @(negedge clk);
        check("t1_pulse_end", 32'(if3.out_valid), 32'd0);
        check("t1_in_ready",  32'(if3.in_ready),  32'd1);
        check("t1_busy",      32'(if3.busy),      32'd0);
        drain("t1");

        // 2: extreme operands; zeros still take the full RUN time.
        txn3(5'd31, 5'd31, "t2_max");
        txn3(5'd0,  5'd31, "t2_a0");
        txn3(5'd31, 5'd0,  "t2_b0");
        drain("t2");

        // 3: backpressure holds out_valid and p stable.
        or3_dir = 1'b0;
        txn3(5'd7, 5'd9, "t3");
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_valid",    32'(if3.out_valid), 32'd1);
            check("t3_hold_p",        32'(if3.p),         32'd63);
            check("t3_hold_in_ready", 32'(if3.in_ready),  32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        or3_dir = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_after_valid",    32'(if3.out_valid), 32'd0);
        check("t3_after_in_ready", 32'(if3.in_ready),  32'd1);
        drain("t3");

        // 4: in_valid during RUN/DONE is ignored; next pair only after transfer.
        or3_dir = 1'b0;
        send3(5'd6, 5'd5);
        if3.in_valid = 1'b1;
        if3.a        = 5'd1;
        if3.b        = 5'd1;
        for (int i = 0; i < ITER3 + 3; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", 32'(if3.in_ready), 32'd0);
        end
        check("t4_p_held", 32'(if3.p), 32'd30);
        q3.push_back(1);
        @(posedge clk); #1;
        or3_dir = 1'b1;
        @(negedge clk);
        check("t4_in_ready_at_xfer", 32'(if3.in_ready), 32'd0);
        @(negedge clk);
        check("t4_in_ready_after", 32'(if3.in_ready), 32'd1);
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
        drain("t4");

        // 5: async reset mid-RUN discards the product.
        send3(5'd12, 5'd10);
        @(negedge clk);
        check("t5_busy_run", 32'(if3.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(if3.out_valid), 32'd0);
        check("t5_rst_busy",      32'(if3.busy),      32'd0);
        check("t5_rst_p",         32'(if3.p),         32'd0);
        q3.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_in_ready", 32'(if3.in_ready), 32'd1);
        txn3(5'd2, 5'd2, "t5_after");
        drain("t5");

        // Random pairs on the default instance with random backpressure.
        rand_bp3 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send3(5'($urandom), 5'($urandom));
        end
        drain("rand");
        rand_bp3 = 1'b0;

        // 6: exhaustive sweeps on J=1 and J=5 in parallel.
        fork
            begin : sweep_j1
                int g1;
                for (int av = 0; av < 32; av++) begin
                    for (int bv = 0; bv < 32; bv++) begin
                        g1 = 0;
                        @(posedge clk); #1;
                        if1.in_valid = 1'b1;
                        if1.a        = 5'(av);
                        if1.b        = 5'(bv);
                        do begin
                            @(negedge clk);
                            g1++;
                        end while (!if1.in_ready && g1 < 200);
                        if (!if1.in_ready) check("j1_accept_timeout", 32'd0, 32'd1);
                        q1.push_back(av * bv);
                        @(posedge clk); #1;
                        if1.in_valid = 1'b0;
                    end
                end
            end
            begin : sweep_j5
                int g5;
                for (int av = 0; av < 32; av++) begin
                    for (int bv = 0; bv < 32; bv++) begin
                        g5 = 0;
                        @(posedge clk); #1;
                        if5.in_valid = 1'b1;
                        if5.a        = 5'(av);
                        if5.b        = 5'(bv);
                        do begin
                            @(negedge clk);
                            g5++;
                        end while (!if5.in_ready && g5 < 200);
                        if (!if5.in_ready) check("j5_accept_timeout", 32'd0, 32'd1);
                        q5.push_back(av * bv);
                        @(posedge clk); #1;
                        if5.in_valid = 1'b0;
                    end
                end
            end
        join
        drain("sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
